seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width in bits.
REQ-003 Parameter DEFAULT_PAT, default 4'b0101, width N: pattern loaded at reset; bit N-1 is the first bit received, bit 0 the last.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  qualifies din; din is ignored when low.
REQ-008 overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping matches.
REQ-009 pat_load  input  1  load strobe for pat_in.
REQ-010 pat_in  input  N  new pattern, same bit order as DEFAULT_PAT.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 y  output  1  Mealy match flag, combinational from the current state, din, din_valid and pat_load.
REQ-013 y_reg  output  1  y delayed by one clock.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 State SHALL be: the pattern register pat[N-1:0], the history register hist[N-2:0] holding the most recent valid bits (newest in bit 0), and the fill counter fill (0..N-1).
REQ-016 y SHALL be 1 only when din_valid=1, pat_load=0, fill=N-1 and {hist,din}=pat; otherwise y=0.
REQ-017 When din_valid=1 and pat_load=0, hist SHALL shift left with din entering bit 0, and fill SHALL increment and saturate at N-1.
REQ-018 When y=1 and overlap_en=1, hist and fill SHALL update as in REQ-017, so a new match can complete on the next valid bit if the pattern allows it.
REQ-019 When y=1 and overlap_en=0, fill SHALL be cleared to 0, so a new match requires N fresh valid bits.
REQ-020 When din_valid=0, hist and fill SHALL hold; valid gaps of any length are transparent to matching.
REQ-021 When pat_load=1, pat SHALL take pat_in and fill SHALL clear to 0; din is ignored that cycle even if din_valid=1.
REQ-022 Update priority SHALL be: reset, then pat_load, then din_valid.
REQ-023 overlap_en SHALL be sampled every cycle and may change between bits; only the value in the matching cycle applies.
REQ-024 y_reg SHALL equal the value of y in the previous cycle.
REQ-025 match_cnt SHALL increment on each cycle with y=1 and saturate at 2^CNT_W-1.
REQ-026 If cnt_clr=1, match_cnt SHALL become 0 regardless of y in the same cycle.
REQ-027 Detection latency SHALL be zero cycles on y and one cycle on y_reg and match_cnt.

Reset
REQ-028 When reset_n=0 at a clock edge, the block SHALL set pat=DEFAULT_PAT, hist=0, fill=0, y_reg=0 and match_cnt=0.
REQ-029 Reset SHALL override pat_load, din_valid and cnt_clr in the same cycle.
REQ-030 y SHALL be 0 in the first cycle after reset, because fill=0.
REQ-031 Asserting reset mid-stream SHALL discard any partial match.

Configuration
REQ-032 Macro SEQ_DETECT_COUNT_EN SHALL control the match counter.
REQ-033 With the macro defined, match_cnt SHALL behave per REQ-025 and REQ-026.
REQ-034 Without the macro, match_cnt SHALL remain a port, be driven constant 0, cnt_clr SHALL be ignored, and no counter flops SHALL be inferred; y and y_reg are unaffected.

Verification
REQ-035 Bench SHALL cover: N=4, default pattern, overlap_en=1, din 0,1,0,1,0,1 every cycle -> y=1 on bits 4 and 6 only; match_cnt=2.
REQ-036 Bench SHALL cover: same stream extended to 0,1,0,1,0,1,0,1 with overlap_en=0 -> y=1 on bits 4 and 8 only.
REQ-037 Bench SHALL cover: 0,1,0,1 with din_valid=0 for 3 cycles between every bit and din toggling randomly while invalid -> exactly one y pulse, on the 4th valid bit.
REQ-038 Bench SHALL cover: pat_load with pat_in=4'b1100 after bits 1,1 -> history discarded; stream 1,1,0,0 -> y=1 on the final 0.
REQ-039 Bench SHALL cover: CNT_W=2 with 5 matches -> match_cnt reads 3; cnt_clr and y asserted together -> match_cnt=0 next cycle.
REQ-040 Bench SHALL cover: reset_n=0 after bits 0,1,0, then 1 -> no y; y_reg=0; pat=0101 restored.

Source files
------------

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial pattern detector with a loadable N-bit pattern, optional overlapping
// matches, a zero-latency Mealy match flag (y), its registered copy (y_reg)
// and a saturating match counter.
//
// Build option:
//   SEQ_DETECT_COUNT_EN  defined   -> match_cnt counts matches, cnt_clr clears it
//                        undefined -> match_cnt tied to 0, cnt_clr ignored,
//                                     no counter flops
// -----------------------------------------------------------------------------
module seq_detect_param #(
   parameter int               N           = 4,
   parameter int               CNT_W       = 8,
   parameter logic [N-1:0]     DEFAULT_PAT = N'(4'b0101)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               overlap_en,
   input  logic               pat_load,
   input  logic [N-1:0]       pat_in,
   input  logic               cnt_clr,
   output logic               y,
   output logic               y_reg,
   output logic [CNT_W-1:0]   match_cnt
);

   // Fill counter must reach N-1; N >= 2 keeps the width at least one bit.
   localparam int               FILL_W   = $clog2(N);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);

   logic [N-1:0]       pat_q;
   logic [N-1:0]       pat_d;
   logic [N-2:0]       hist_q;
   logic [N-2:0]       hist_d;
   logic [FILL_W-1:0]  fill_q;
   logic [FILL_W-1:0]  fill_d;
   logic               y_reg_q;
   logic [N-1:0]       window_s;
   logic               y_s;

   // Candidate window: stored history with the current bit appended as newest.
   assign window_s = {hist_q, din};

   // Mealy match flag: only a valid, non-load cycle with a full history can match.
   always_comb begin
      y_s = 1'b0;
      if (din_valid && !pat_load && (fill_q == FILL_MAX) && (window_s == pat_q)) begin
         y_s = 1'b1;
      end else begin
         y_s = 1'b0;
      end
   end

   // Next-state selection: pattern load wins over data, idle cycles hold state.
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (pat_load) begin
         pat_d  = pat_in;
         fill_d = '0;
      end else if (din_valid) begin
         hist_d = window_s[N-2:0];
         if (y_s && !overlap_en) begin
            // Non-overlapping: the bits of this match may not be reused.
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         pat_d  = pat_q;
         hist_d = hist_q;
         fill_d = fill_q;
      end
   end

   // Detector state and delayed match flag, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pat_q   <= DEFAULT_PAT;
         hist_q  <= '0;
         fill_q  <= '0;
         y_reg_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         y_reg_q <= y_s;
      end
   end

   assign y     = y_s;
   assign y_reg = y_reg_q;

`ifdef SEQ_DETECT_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Counter next value: clear beats a same-cycle match, otherwise saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (y_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Match counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   // Counter compiled out: port kept, clear input intentionally unused.
   logic unused_cnt_clr_s;
   assign unused_cnt_clr_s = cnt_clr;
   assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// Self-checking bench for seq_detect_param (N=4, CNT_W=2, pattern 0101).
// Expected y values are pushed to a scoreboard queue as each bit is driven and
// popped when the combinational output is sampled on the falling edge.
// Counter expectations follow SEQ_DETECT_COUNT_EN (0 when compiled out).
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

   localparam int N     = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             din;
   logic             din_valid;
   logic             overlap_en;
   logic             pat_load;
   logic [N-1:0]     pat_in;
   logic             cnt_clr;
   logic             y;
   logic             y_reg;
   logic [CNT_W-1:0] match_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   bit exp_q[$];
   bit prev_y;

   seq_detect_param #(
      .N           (N),
      .CNT_W       (CNT_W),
      .DEFAULT_PAT (4'b0101)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .overlap_en (overlap_en),
      .pat_load   (pat_load),
      .pat_in     (pat_in),
      .cnt_clr    (cnt_clr),
      .y          (y),
      .y_reg      (y_reg),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CNT_W-1:0] cnt_exp(input int v);
`ifdef SEQ_DETECT_COUNT_EN
      return CNT_W'(v);
`else
      return '0;
`endif
   endfunction

   // Drive one cycle of input and record the y value that cycle must show.
   task automatic drive(input bit v, input bit d, input bit e);
      din_valid = v;
      din       = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      din_valid  = 1'b0;
      din        = 1'b0;
      pat_load   = 1'b0;
      pat_in     = 4'b0000;
      cnt_clr    = 1'b0;
      overlap_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      prev_y  = 1'b0;
   endtask

   task automatic test_reset();
      bit e;
      reset_n    = 1'b0;
      din_valid  = 1'b1;
      din        = 1'b1;
      pat_load   = 1'b1;
      pat_in     = 4'b1111;
      cnt_clr    = 1'b0;
      overlap_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      pat_load = 1'b0;
      @(negedge clk);
      n_checks++;
      if (y_reg !== 1'b0) $display("FAIL reset_y_reg: got %b expected 0", y_reg);
      else n_pass++;
      n_checks++;
      if (match_cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", match_cnt);
      else n_pass++;
      @(posedge clk);
      #1;
      // A reset-time pattern load must not take: 1111 must not be detected.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL reset_y bit%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
   endtask

   task automatic test_overlap();
      bit bits[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit ey[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bit e;
      do_reset();
      overlap_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, bits[i], ey[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL overlap_y bit%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         n_checks++;
         if (y_reg !== prev_y) $display("FAIL overlap_y_reg bit%0d: got %b expected %b", i + 1, y_reg, prev_y);
         else n_pass++;
         prev_y = e;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (match_cnt !== cnt_exp(2)) $display("FAIL overlap_cnt: got %0d expected %0d", match_cnt, cnt_exp(2));
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_non_overlap();
      bit e;
      do_reset();
      overlap_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, bit'(i % 2), bit'(i == 3 || i == 7));
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL nonoverlap_y bit%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (match_cnt !== cnt_exp(2)) $display("FAIL nonoverlap_cnt: got %0d expected %0d", match_cnt, cnt_exp(2));
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_valid_gaps();
      bit e;
      do_reset();
      overlap_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, bit'(i % 2), bit'(i == 3));
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL gaps_y valid%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, bit'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (y !== e) $display("FAIL gaps_y idle%0d.%0d: got %b expected %b", i + 1, g, y, e);
            else n_pass++;
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      n_checks++;
      if (match_cnt !== cnt_exp(1)) $display("FAIL gaps_cnt: got %0d expected %0d", match_cnt, cnt_exp(1));
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_pat_load();
      bit bits[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      bit ey[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bit e;
      do_reset();
      overlap_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         // Third cycle loads 1100 while a valid 0 is presented and ignored.
         pat_load = (i == 2);
         pat_in   = (i == 2) ? 4'b1100 : 4'b0000;
         drive(1'b1, bits[i], ey[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL patload_y step%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         n_checks++;
         if (y_reg !== prev_y) $display("FAIL patload_y_reg step%0d: got %b expected %b", i + 1, y_reg, prev_y);
         else n_pass++;
         prev_y = e;
         @(posedge clk);
         #1;
      end
      pat_load  = 1'b0;
      din_valid = 1'b0;
   endtask

   task automatic test_saturate_clear();
      bit e;
      do_reset();
      overlap_en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         drive(1'b1, bit'((i % 2) == 0), bit'(i >= 4 && (i % 2) == 0));
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL sat_y bit%0d: got %b expected %b", i, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (match_cnt !== cnt_exp(3)) $display("FAIL sat_cnt: got %0d expected %0d", match_cnt, cnt_exp(3));
      else n_pass++;
      @(posedge clk);
      #1;
      for (int i = 13; i <= 14; i++) begin
         cnt_clr = (i == 14);
         drive(1'b1, bit'((i % 2) == 0), bit'(i == 14));
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL clr_y bit%0d: got %b expected %b", i, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      cnt_clr   = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (match_cnt !== '0) $display("FAIL clr_cnt: got %0d expected 0", match_cnt);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midstream();
      bit pre[3]  = '{1'b0, 1'b1, 1'b0};
      bit post[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit epst[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bit e;
      do_reset();
      // Move away from the default pattern so the reset must restore it.
      pat_load = 1'b1;
      pat_in   = 4'b1111;
      @(posedge clk);
      #1;
      pat_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pre[i], 1'b0);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL midrst_pre_y bit%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      reset_n   = 1'b0;
      din_valid = 1'b1;
      din       = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      prev_y  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, post[i], epst[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e) $display("FAIL midrst_y bit%0d: got %b expected %b", i + 1, y, e);
         else n_pass++;
         n_checks++;
         if (y_reg !== prev_y) $display("FAIL midrst_y_reg bit%0d: got %b expected %b", i + 1, y_reg, prev_y);
         else n_pass++;
         prev_y = e;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_valid_gaps();
      test_pat_load();
      test_saturate_clear();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
